fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the Jac1-8 core. It owns the program counter and the instruction register, and reads 16-bit instruction words from a synchronous program ROM. It presents one instruction at a time to the combinational decoder and computes the next PC from the decoder's `cnt_wr_en`, `add_offset` and `literal_adr` outputs. Every instruction takes a fixed three-cycle fetch/load/execute sequence.

## Interface
- `PC_WIDTH`, default 8: program counter and program address width.
- `PROGRAM_DataWidth`, default 16: instruction word width.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `run`  in  1: level; high lets the core fetch and execute.
- `prog_addr`  out  PC_WIDTH: program ROM address; always equals `pc`.
- `prog_data`  in  PROGRAM_DataWidth: ROM read data; valid one cycle after the address is presented.
- `instruction`  out  PROGRAM_DataWidth: drives the decoder input. Equals the IR in EXEC and 16'h0000 (NOP) in every other state.
- `instr_valid`  out  1: high only in EXEC.
- `cnt_wr_en`  in  1: from the decoder; load the PC instead of incrementing it.
- `add_offset`  in  1: from the decoder; the load is PC-relative.
- `literal_adr`  in  PC_WIDTH: from the decoder; absolute target or signed offset.
- `pc`  out  PC_WIDTH: current program counter.
- `halted`  out  1: high in IDLE.

## Operation
- States are IDLE, FETCH, LOAD and EXEC.
- IDLE: enters FETCH on the next edge if `run` is 1; otherwise stays in IDLE.
- FETCH: `prog_addr = pc`; the ROM samples the address at the end of the cycle. Always goes to LOAD.
- LOAD: IR <= `prog_data` at the end of the cycle. Always goes to EXEC.
- EXEC: IR drives `instruction`, the decoder settles combinationally, and the PC updates at the end of the cycle.
  - Next state is FETCH if `run` is 1, else IDLE.
- Next-PC rule, applied only at the end of EXEC:
  - `cnt_wr_en`=0: PC <= PC + 1.
  - `cnt_wr_en`=1 and `add_offset`=0: PC <= `literal_adr`.
  - `cnt_wr_en`=1 and `add_offset`=1: PC <= PC + sign-extended `literal_adr`. PC is the address of the branch instruction itself, and the offset range is -128..+127.
- All PC arithmetic is modulo 2^PC_WIDTH: 0xFF+1 wraps to 0x00, and carries are discarded.
- PC and IR hold their values in IDLE, FETCH and LOAD; `cnt_wr_en` and `add_offset` are ignored outside EXEC.
- Forcing NOP outside EXEC guarantees the decoder asserts no `wr_en` or `stat_wr_en` during FETCH, LOAD or IDLE.
- Deasserting `run` does not abort an instruction in flight. The current FETCH, LOAD and EXEC sequence completes, the PC updates, then the stage goes to IDLE.
- Reasserting `run` in IDLE resumes at the stored PC.

## Timing
- Reset values:
  - state IDLE, `pc`/`prog_addr` 0x00;
  - IR 0x0000 and `instruction` 0x0000;
  - `instr_valid` 0, `halted` 1.
- Asserting `rst_n` low in any state, EXEC included, forces the reset values immediately, without waiting for a clock edge, and no PC update takes effect.
- Release of `rst_n` is synchronised externally; the first state transition happens on the first rising edge with `rst_n`=1.
- Latency: sample `run` high in IDLE at edge E0, then FETCH in E0..E1, LOAD in E1..E2 and EXEC in E2..E3. The new PC is visible after E3.
- Steady-state throughput with `run` held high is one instruction per 3 cycles.
- `instr_valid` is a one-cycle pulse per instruction; `instruction` changes only at state edges, with no glitching from `prog_data`.
- `halted` rises in the cycle after the final EXEC.

## Structure
- Shared package `jac_pkg`:
  - state encoding (2-bit enum: IDLE, FETCH, LOAD, EXEC);
  - `NOP_WORD` = 16'h0000;
  - `PC_WIDTH` and `PROGRAM_DataWidth` defaults, shared with the decoder.
- Sub-module `pc_next_calc`: combinational. Inputs are `pc`, `cnt_wr_en`, `add_offset` and `literal_adr`; output is `pc_next`. It holds the sign extension and wrap arithmetic so it can be unit-tested alone.
- Everything else (state register, PC, IR) lives flat in `fetch_unit`.

## Test plan
- Reset: drive `rst_n`=0 with `run`=1. Expect `pc`=0x00, `instruction`=0x0000, `halted`=1 and `instr_valid`=0. Release reset; FETCH is reached on the first edge.
- Sequential run: ROM[0]=0x4A05, ROM[1]=0x0A10, decoder `cnt_wr_en`=0. Expect `instruction`=0x4A05 only in cycle 3 and 0x0A10 only in cycle 6, with `pc` stepping 0x00 to 0x01 to 0x02.
- Absolute jump: at PC 0x10, EXEC with `cnt_wr_en`=1, `add_offset`=0, `literal_adr`=0x40. Expect next FETCH `prog_addr`=0x40.
- Relative branch:
  - at PC 0x05 with offset 0xFE, expect PC 0x03;
  - at PC 0xFF with offset 0x02, expect PC 0x01;
  - at PC 0xFF with `cnt_wr_en`=0, expect PC 0x00.
- Run drop: deassert `run` during LOAD at PC 0x07. Expect the EXEC pulse to still occur, PC to become 0x08 and `halted`=1 next cycle. Reassert `run`; the next fetch is at 0x08.
- Mid-EXEC reset: pulse `rst_n` low between edges during EXEC with `cnt_wr_en`=1, `literal_adr`=0x80. Expect `pc`=0x00 and `instruction`=0x0000 immediately, and PC never equal to 0x80.

Source files
------------

// File: rtl/jac_pkg.sv
// ----------------------------------------------------------------------------
// jac_pkg: shared types and defaults for the Jac1-8 fetch stage and decoder
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package jac_pkg;

    localparam int DEFAULT_PC_WIDTH        = 8;
    localparam int DEFAULT_PROG_DATA_WIDTH = 16;

    localparam logic [15:0] NOP_WORD = 16'h0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2,
        S_EXEC  = 2'd3
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_next_calc.sv
// ----------------------------------------------------------------------------
// pc_next_calc: next program counter (increment, absolute load, relative branch)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pc_next_calc
    import jac_pkg::*;
#(
    parameter int PC_WIDTH = DEFAULT_PC_WIDTH
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                cnt_wr_en,
    input  logic                add_offset,
    input  logic [PC_WIDTH-1:0] literal_adr,
    output logic [PC_WIDTH-1:0] pc_next
);

    // The offset is as wide as the PC, so adding it modulo 2^PC_WIDTH
    // is the same as adding its sign extension and dropping the carry.
    always_comb begin
        pc_next = pc + PC_WIDTH'(1);
        if (cnt_wr_en) begin
            if (add_offset) begin
                pc_next = pc + literal_adr;
            end else begin
                pc_next = literal_adr;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit: Jac1-8 fetch stage owning PC and IR, three-cycle fetch/load/exec
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_unit
    import jac_pkg::*;
#(
    parameter int PC_WIDTH          = DEFAULT_PC_WIDTH,
    parameter int PROGRAM_DataWidth = DEFAULT_PROG_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         run,
    output logic [PC_WIDTH-1:0]          prog_addr,
    input  logic [PROGRAM_DataWidth-1:0] prog_data,
    output logic [PROGRAM_DataWidth-1:0] instruction,
    output logic                         instr_valid,
    input  logic                         cnt_wr_en,
    input  logic                         add_offset,
    input  logic [PC_WIDTH-1:0]          literal_adr,
    output logic [PC_WIDTH-1:0]          pc,
    output logic                         halted
);

    fetch_state_t                 state;
    fetch_state_t                 state_next;
    logic [PROGRAM_DataWidth-1:0] ir;
    logic [PC_WIDTH-1:0]          pc_next;

    pc_next_calc #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next_calc (
        .pc          (pc),
        .cnt_wr_en   (cnt_wr_en),
        .add_offset  (add_offset),
        .literal_adr (literal_adr),
        .pc_next     (pc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= PROGRAM_DataWidth'(NOP_WORD);
        end else begin
            state <= state_next;
            if (state == S_LOAD) begin
                ir <= prog_data;
            end
            if (state == S_EXEC) begin
                pc <= pc_next;
            end
        end
    end

    // run is only consulted at instruction boundaries, so dropping it
    // never cuts an instruction short.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = run ? S_FETCH : S_IDLE;
            S_FETCH: state_next = S_LOAD;
            S_LOAD:  state_next = S_EXEC;
            S_EXEC:  state_next = run ? S_FETCH : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // The decoder sees a NOP outside EXEC so it cannot fire side effects.
    assign instruction = (state == S_EXEC) ? ir : PROGRAM_DataWidth'(NOP_WORD);
    assign instr_valid = (state == S_EXEC);
    assign halted      = (state == S_IDLE);
    assign prog_addr   = pc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit: directed and randomized self-checking bench for fetch_unit
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [7:0]  prog_addr;
    logic [15:0] prog_data;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        cnt_wr_en;
    logic        add_offset;
    logic [7:0]  literal_adr;
    logic [7:0]  pc;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [15:0] rom [256];
    int          mpc;

    fetch_unit #(
        .PC_WIDTH          (8),
        .PROGRAM_DataWidth (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .cnt_wr_en   (cnt_wr_en),
        .add_offset  (add_offset),
        .literal_adr (literal_adr),
        .pc          (pc),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data for an address appears one cycle later.
    always @(posedge clk) prog_data <= rom[prog_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_next(input int p, input logic cw, input logic ao, input logic [7:0] lit);
        if (!cw) return (p + 1) % 256;
        if (!ao) return int'(lit);
        return (p + int'($signed(lit)) + 256) % 256;
    endfunction

    task automatic junk_decoder();
        cnt_wr_en   = 1'($urandom);
        add_offset  = 1'($urandom);
        literal_adr = 8'($urandom);
    endtask

    // Entered just after the edge that starts FETCH; leaves in EXEC.
    task automatic fetch_to_exec(input bit run_after);
        chk("fetch_addr", prog_addr, mpc);
        chk("fetch_instr", instruction, 16'h0000);
        chk("fetch_valid", instr_valid, 1'b0);
        chk("fetch_halted", halted, 1'b0);
        junk_decoder();
        tick();
        chk("load_instr", instruction, 16'h0000);
        chk("load_valid", instr_valid, 1'b0);
        chk("load_pc", pc, mpc);
        run = run_after;
        junk_decoder();
        tick();
        chk("exec_instr", instruction, rom[mpc]);
        chk("exec_valid", instr_valid, 1'b1);
        chk("exec_pc", pc, mpc);
    endtask

    task automatic finish_exec(input logic cw, input logic ao, input logic [7:0] lit, input bit run_after);
        cnt_wr_en   = cw;
        add_offset  = ao;
        literal_adr = lit;
        mpc = ref_next(mpc, cw, ao, lit);
        tick();
        chk("next_pc", pc, mpc);
        chk("next_halted", halted, !run_after);
        chk("next_valid", instr_valid, 1'b0);
    endtask

    task automatic do_instr(input logic cw, input logic ao, input logic [7:0] lit, input bit run_after);
        fetch_to_exec(run_after);
        finish_exec(cw, ao, lit, run_after);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[0] = 16'h4A05;
        rom[1] = 16'h0A10;
        rst_n = 1'b0;
        run   = 1'b1;
        junk_decoder();
        mpc = 0;

        #3;
        chk("rst_pc", pc, 8'h00);
        chk("rst_instr", instruction, 16'h0000);
        chk("rst_halted", halted, 1'b1);
        chk("rst_valid", instr_valid, 1'b0);
        tick();
        chk("rst_hold_pc", pc, 8'h00);
        chk("rst_hold_halted", halted, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Sequential run from 0x00.
        do_instr(1'b0, 1'b0, 8'h00, 1'b1);
        do_instr(1'b0, 1'b0, 8'h00, 1'b1);
        chk("seq_pc2", pc, 8'h02);

        // Absolute jumps: reach 0x10, then jump to 0x40.
        do_instr(1'b1, 1'b0, 8'h10, 1'b1);
        do_instr(1'b1, 1'b0, 8'h40, 1'b1);
        chk("abs_addr", prog_addr, 8'h40);

        // Relative branches and wrap.
        do_instr(1'b1, 1'b0, 8'h05, 1'b1);
        do_instr(1'b1, 1'b1, 8'hFE, 1'b1);
        chk("rel_back", pc, 8'h03);
        do_instr(1'b1, 1'b0, 8'hFF, 1'b1);
        do_instr(1'b1, 1'b1, 8'h02, 1'b1);
        chk("rel_wrap", pc, 8'h01);
        do_instr(1'b1, 1'b0, 8'hFF, 1'b1);
        do_instr(1'b0, 1'b1, 8'h33, 1'b1);
        chk("inc_wrap", pc, 8'h00);

        // Run drop during LOAD at 0x07.
        do_instr(1'b1, 1'b0, 8'h07, 1'b1);
        do_instr(1'b0, 1'b0, 8'h00, 1'b0);
        chk("drop_pc", pc, 8'h08);
        for (int i = 0; i < 4; i++) begin
            junk_decoder();
            tick();
            chk("idle_halted", halted, 1'b1);
            chk("idle_pc", pc, 8'h08);
            chk("idle_instr", instruction, 16'h0000);
        end
        run = 1'b1;
        tick();
        chk("resume_addr", prog_addr, 8'h08);

        // Randomized instruction stream with occasional run drops.
        for (int n = 0; n < 60; n++) begin
            bit ra;
            ra = ($urandom_range(0, 7) != 0);
            do_instr(1'($urandom), 1'($urandom), 8'($urandom), ra);
            if (!ra) begin
                repeat ($urandom_range(0, 3)) begin
                    junk_decoder();
                    tick();
                    chk("rnd_idle_pc", pc, mpc);
                end
                run = 1'b1;
                tick();
            end
        end

        // Asynchronous reset in the middle of EXEC.
        fetch_to_exec(1'b1);
        cnt_wr_en   = 1'b1;
        add_offset  = 1'b0;
        literal_adr = 8'h80;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc", pc, 8'h00);
        chk("arst_instr", instruction, 16'h0000);
        chk("arst_valid", instr_valid, 1'b0);
        chk("arst_halted", halted, 1'b1);
        tick();
        chk("arst_pc_after_edge", pc, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        mpc = 0;
        tick();
        do_instr(1'b0, 1'b0, 8'h00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
